// File: rtl/avg_pkg.sv
// ----------------------------------------------------------------------------
// avg_pkg
// Shared definitions for the sliding-window averager:
//   - result mode encodings (mean / nearest window sample not above the mean)
//   - running-sum width helper
//   - window-depth legality helper
// No ports (package).
// ----------------------------------------------------------------------------
package avg_pkg;

   localparam logic MODE_MEAN    = 1'b0;
   localparam logic MODE_NEAREST = 1'b1;

   localparam int WIN_MIN = 2;
   localparam int WIN_MAX = 64;

   // Width that holds WIN*(2^DW-1) without wrapping.
   function automatic int calc_sw(input int dw, input int win);
      return dw + $clog2(win);
   endfunction

   function automatic bit win_legal(input int win);
      return (win >= WIN_MIN) && (win <= WIN_MAX);
   endfunction

endpackage

// File: rtl/avg_nearest_sel.sv
// ----------------------------------------------------------------------------
// avg_nearest_sel
// Combinational selector: largest buffer entry that does not exceed mean.
// Entries above the mean are replaced by zero, then a binary max tree reduces
// them. Zero is a safe filler because all values are unsigned and at least
// one real entry always qualifies (the minimum never exceeds the mean).
// Ports:
//   entries  in  WIN*DW  flattened window, entry i at [i*DW +: DW]
//   mean     in  DW      truncated window mean
//   nearest  out DW      max{ entry : entry <= mean }
// ----------------------------------------------------------------------------
module avg_nearest_sel #(
   parameter int DW  = 16,
   parameter int WIN = 12
) (
   input  logic [WIN*DW-1:0] entries,
   input  logic [DW-1:0]     mean,
   output logic [DW-1:0]     nearest
);

   // Tree padded to a power of two; heap layout, leaves at LEAVES..2*LEAVES-1.
   localparam int LEAVES = 1 << $clog2(WIN);

   logic [DW-1:0] node_s [1:2*LEAVES-1];

   // Filter the leaves against the mean, then reduce bottom-up to node 1.
   always_comb begin
      for (int n = 1; n < 2 * LEAVES; n++) begin
         node_s[n] = '0;
      end
      for (int i = 0; i < WIN; i++) begin
         if (entries[i*DW +: DW] <= mean) begin
            node_s[LEAVES + i] = entries[i*DW +: DW];
         end else begin
            node_s[LEAVES + i] = '0;
         end
      end
      for (int n = LEAVES - 1; n >= 1; n--) begin
         if (node_s[2*n] > node_s[2*n + 1]) begin
            node_s[n] = node_s[2*n];
         end else begin
            node_s[n] = node_s[2*n + 1];
         end
      end
      nearest = node_s[1];
   end

endmodule

// File: rtl/avg_window.sv
// ----------------------------------------------------------------------------
// avg_window
// Sliding-window averager over the last WIN unsigned samples. Once the window
// is full, every accepted sample yields one result a cycle later: either the
// truncated mean or the largest window sample not exceeding that mean.
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous reset, active low
//   clear      in   1   synchronous window flush (drops that cycle's sample)
//   din_valid  in   1   sample qualifier
//   din        in   DW  sample
//   mode       in   1   MODE_MEAN / MODE_NEAREST, captured with the sample
//   ready      out  1   one-cycle result strobe
//   dout       out  DW  result, holds between strobes
// ----------------------------------------------------------------------------
module avg_window
   import avg_pkg::*;
#(
   parameter int DW  = 16,
   parameter int WIN = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          din_valid,
   input  logic [DW-1:0] din,
   input  logic          mode,
   output logic          ready,
   output logic [DW-1:0] dout
);

   localparam int SW = calc_sw(DW, WIN);
   localparam int PW = $clog2(WIN);
   localparam int CW = $clog2(WIN + 1);

   localparam logic [PW-1:0] PTR_LAST = PW'(WIN - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIN);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIN - 1);
   localparam logic [SW-1:0] WIN_DIV  = SW'(WIN);

   if (!win_legal(WIN)) begin : g_win_check
      $error("avg_window: WIN must lie in 2..64");
   end

   logic [DW-1:0]     buf_r [WIN];
   logic [PW-1:0]     ptr_r;
   logic [CW-1:0]     count_r;
   logic [SW-1:0]     sum_r;
   logic              s1_valid_r;
   logic              s1_mode_r;

   logic              accept_s;
   logic              full_s;
   logic              fills_s;
   logic [DW-1:0]     old_s;
   logic [PW-1:0]     ptr_nxt_s;
   logic [CW-1:0]     count_nxt_s;
   logic [SW-1:0]     sum_nxt_s;
   logic [DW-1:0]     mean_s;
   logic [DW-1:0]     nearest_s;
   logic [DW-1:0]     result_s;
   logic [WIN*DW-1:0] buf_flat_s;

   // Accept decode and next values for pointer, fill count and running sum.
   always_comb begin
      accept_s = din_valid & ~clear;
      full_s   = (count_r == CNT_FULL);
      // The accept that brings the count to WIN (or keeps it there) owns a result.
      fills_s  = accept_s & (count_r >= CNT_LAST);
      // Oldest entry leaves the sum on the same edge it is overwritten.
      if (full_s) begin
         old_s = buf_r[ptr_r];
      end else begin
         old_s = '0;
      end
      if (ptr_r == PTR_LAST) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = ptr_r + PW'(1);
      end
      if (full_s) begin
         count_nxt_s = count_r;
      end else begin
         count_nxt_s = count_r + CW'(1);
      end
      sum_nxt_s = sum_r + SW'(din) - SW'(old_s);
   end

   // Mean of the current window; the quotient always fits DW bits.
   always_comb begin
      mean_s = DW'(sum_r / WIN_DIV);
   end

   // Present the buffer as one flat vector to the nearest-sample selector.
   always_comb begin
      buf_flat_s = '0;
      for (int i = 0; i < WIN; i++) begin
         buf_flat_s[i*DW +: DW] = buf_r[i];
      end
   end

   avg_nearest_sel #(
      .DW  (DW),
      .WIN (WIN)
   ) u_nearest (
      .entries (buf_flat_s),
      .mean    (mean_s),
      .nearest (nearest_s)
   );

   // Result select using the mode captured with the sample.
   always_comb begin
      if (s1_mode_r == MODE_NEAREST) begin
         result_s = nearest_s;
      end else begin
         result_s = mean_s;
      end
   end

   // Sample storage; contents are never read before being written.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         buf_r[ptr_r] <= din;
      end
   end

   // Window bookkeeping and stage-1 capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_r      <= '0;
         count_r    <= '0;
         sum_r      <= '0;
         s1_valid_r <= 1'b0;
         s1_mode_r  <= MODE_MEAN;
      end else begin
         s1_valid_r <= fills_s;
         if (clear) begin
            ptr_r   <= '0;
            count_r <= '0;
            sum_r   <= '0;
         end else if (accept_s) begin
            ptr_r     <= ptr_nxt_s;
            count_r   <= count_nxt_s;
            sum_r     <= sum_nxt_s;
            s1_mode_r <= mode;
         end
      end
   end

   // Stage 2: registered result and one-cycle strobe. A result captured in
   // stage 1 completes even if clear arrives on this edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready <= 1'b0;
         dout  <= '0;
      end else begin
         ready <= s1_valid_r;
         if (s1_valid_r) begin
            dout <= result_s;
         end
      end
   end

endmodule
